// File: rtl/puf_response_engine.sv
// puf_response_engine: arbiter-PUF style response generator.
// K modelled delay chains each race over an N-bit challenge register C.
// Every SETTLE+1 cycles one response bit is evaluated and then C is LFSR-stepped.
// M bits are assembled MSB-first and held in DONE until the consumer accepts them.
// Optional macro PUF_RESP_PARITY_EN adds a registered resp_parity output.
module puf_response_engine #(
   parameter int            N      = 128,
   parameter int            K      = 4,
   parameter int            M      = 32,
   parameter int            SETTLE = 4,
   parameter logic [N-1:0]  SEED   = {N/8{8'hA5}},
   parameter logic [N-1:0]  TAPS   = {1'b1, {(N-2){1'b0}}, 1'b1}
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  challenge,
   input  logic          xor_mode,
   output logic          busy,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [M-1:0]  response
`ifdef PUF_RESP_PARITY_EN
   ,
   output logic          resp_parity
`endif
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int BW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [N-1:0]    r_chal;
   logic            r_xor;
   logic [N-1:0]    r_c;
   logic [SW-1:0]   r_scnt;
   logic [BW-1:0]   r_bcnt;
   logic [M-1:0]    r_resp;
   logic [K-1:0]    w_chain;
   logic            w_bit;
   logic [M-1:0]    w_resp_nxt;
   logic            w_fb;

   // Chain k weights are the seed rotated left by k positions.
   function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[(i + s) % N] = v[i];
      return r;
   endfunction

   genvar k;
   generate
      for (k = 0; k < K; k++) begin : g_chain
         localparam logic [N-1:0] MASK = rotl(SEED, k);
         assign w_chain[k] = ^(r_c & MASK);
      end
      if (M == 1) begin : g_shift1
         assign w_resp_nxt = w_bit;
      end else begin : g_shiftn
         assign w_resp_nxt = {r_resp[M-2:0], w_bit};
      end
   endgenerate

   assign w_bit = r_xor ? (^w_chain) : w_chain[0];
   assign w_fb  = ^(r_c & TAPS);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; start only matters in IDLE, so a handshake always lands in IDLE first.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_LOAD;
         ST_LOAD:   w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_scnt == SW'(SETTLE - 1)) w_state_nxt = ST_SAMPLE;
         ST_SAMPLE: w_state_nxt = (r_bcnt == BW'(M - 1)) ? ST_DONE : ST_SETTLE;
         ST_DONE:   if (resp_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
      resp_valid = (r_state == ST_DONE);
   end

   // Datapath: capture, load, settle timing, sample-and-step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_chal <= '0;
         r_xor  <= 1'b0;
         r_c    <= '0;
         r_scnt <= '0;
         r_bcnt <= '0;
         r_resp <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_chal <= challenge;
                  r_xor  <= xor_mode;
               end
            end
            ST_LOAD: begin
               // An all-zero LFSR state would never advance.
               r_c    <= (r_chal == '0) ? '1 : r_chal;
               r_scnt <= '0;
               r_bcnt <= '0;
            end
            ST_SETTLE: r_scnt <= r_scnt + 1'b1;
            ST_SAMPLE: begin
               r_resp <= w_resp_nxt;
               r_c    <= {r_c[N-2:0], w_fb};
               r_scnt <= '0;
               r_bcnt <= (r_bcnt == BW'(M - 1)) ? '0 : r_bcnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign response = r_resp;

`ifdef PUF_RESP_PARITY_EN
   logic r_parity;

   // Parity tracks the response register update for update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                     r_parity <= 1'b0;
      else if (r_state == ST_SAMPLE)  r_parity <= ^w_resp_nxt;
   end

   assign resp_parity = r_parity;
`endif

endmodule

// File: doc/puf_response_engine.md
PUF_RESPONSE_ENGINE -- requirements
Module: puf_response_engine

Interface
REQ-001 SHALL have parameter N, default 128, meaning stages per delay chain and challenge width.
REQ-002 SHALL have parameter K, default 4, meaning number of parallel chains (1..16).
REQ-003 SHALL have parameter M, default 32, meaning response bits per request (1..64).
REQ-004 SHALL have parameter SETTLE, default 4, meaning race-settle cycles per evaluation (>=1).
REQ-005 SHALL have parameter SEED, default {N/8{8'hA5}}, meaning N-bit chain-weight mask base.
REQ-006 SHALL have parameter TAPS, default N'h1 | (1<<(N-1)), meaning N-bit LFSR feedback taps.
REQ-007 SHALL have port clk, input, 1, meaning the only clock; all state on rising edge.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, meaning request strobe, sampled only in IDLE.
REQ-010 SHALL have port challenge, input, N, meaning seed challenge, captured with start.
REQ-011 SHALL have port xor_mode, input, 1, meaning 0 = chain 0 only, 1 = XOR of all K chains; captured with start.
REQ-012 SHALL have port busy, output, 1, meaning high in every state except IDLE and DONE.
REQ-013 SHALL have port resp_valid, output, 1, meaning response held valid (DONE state).
REQ-014 SHALL have port resp_ready, input, 1, meaning consumer accepts response.
REQ-015 SHALL have port response, output, M, meaning assembled response word.

Function
REQ-016 Chain k response bit SHALL be r_k = XOR-reduce(C & MASK_k), MASK_k = SEED rotated left by k, C = current challenge register.
REQ-017 Evaluated bit SHALL be r_0 when captured xor_mode=0, XOR of r_0..r_(K-1) when 1.
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, SAMPLE, DONE.
REQ-019 IDLE->LOAD when start=1; challenge and xor_mode captured; start ignored in all other states.
REQ-020 LOAD (1 cycle): C <= challenge, or all-ones if challenge==0 (LFSR lock-up avoidance); bit counter and settle counter cleared; -> SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE cycles, then -> SAMPLE.
REQ-022 SAMPLE (1 cycle): response <= {response[M-2:0], bit}; C <= {C[N-2:0], XOR-reduce(C & TAPS)}; bit counter +1; -> SETTLE if count<M, else -> DONE.
REQ-023 resp_valid SHALL rise exactly 1+M*(SETTLE+1) cycles after the edge sampling start.
REQ-024 DONE: response and resp_valid SHALL stay stable until resp_ready=1; on that edge -> IDLE, resp_valid cleared, response retained.
REQ-025 resp_valid and resp_ready both high with start high SHALL return to IDLE only; new request needs start in IDLE (one idle cycle minimum).
REQ-026 First response bit SHALL land in response[M-1] after M samples (MSB = first challenge).
REQ-027 challenge/xor_mode changes after capture SHALL not affect an in-flight request.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, busy=0, resp_valid=0, response=0, C=0, all counters=0.
REQ-029 reset asserted mid-request SHALL abort it; no resp_valid is produced for the aborted request.
REQ-030 First evaluation after reset release SHALL require a fresh start.

Configuration
REQ-031 Macro PUF_RESP_PARITY_EN defined: extra output resp_parity (1 bit) = XOR-reduce(response), registered with response, valid with resp_valid, reset 0.
REQ-032 Macro undefined: resp_parity port and logic absent; all other behaviour identical.

Verification (N=8, K=2, M=4, SETTLE=2, SEED=8'h01, TAPS=8'h81 unless stated)
REQ-033 Reset mid-SETTLE -> busy=0, resp_valid=0, response=0 same cycle; no later resp_valid without start.
REQ-034 start, challenge=8'h03, xor_mode=0, M=1 -> r_0=1, response=1'b1, resp_valid exactly 4 cycles after start edge.
REQ-035 start, challenge=8'h00, M=4 -> C loaded as 8'hFF; resp_valid at cycle 13; response matches reference model from 8'hFF.
REQ-036 xor_mode=1, SEED=8'h03, challenge=8'h01 -> r_0=1, r_1=0, first bit=1; same with xor_mode=0 -> first bit=1, then compare full words vs model.
REQ-037 resp_ready held 0 for 20 cycles in DONE -> response and resp_valid stable; start pulses ignored; resp_ready=1 -> IDLE next cycle.
REQ-038 With PUF_RESP_PARITY_EN: response=4'b1011 -> resp_parity=1; build without macro compiles with port absent.
